// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM receive path: framing state encoding
// and slot geometry.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  localparam logic [SLOT_W-1:0] SLOT_LAST = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demux: clear to 0, load 1 after a sync beat,
// or advance with natural 3->0 wrap.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_one,
  input  logic              advance,
  output logic [SLOT_W-1:0] count
);

  logic [SLOT_W-1:0] count_d;
  logic [SLOT_W-1:0] count_q;

  // Priority: clear beats load_one beats advance.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load_one) begin
      count_d = SLOT_W'(1);
    end else if (advance) begin
      count_d = count_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer: hunts for the slot-0 sync flag, stages slots 0..2
// and publishes all four channels together on the slot-3 beat.
//
// Handshake: a beat exists only when in_valid is high on a rising clk edge;
// in_sync and in_data are don't-care otherwise. There is no backpressure.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic              frame_valid,
  output logic              sync_err,
  output logic              locked,
  output logic [SLOT_W-1:0] slot
);

  state_e            state_d, state_q;
  logic [WIDTH-1:0]  stage_d [NUM_SLOTS-1];
  logic [WIDTH-1:0]  stage_q [NUM_SLOTS-1];
  logic [WIDTH-1:0]  out_d   [NUM_SLOTS];
  logic [WIDTH-1:0]  out_q   [NUM_SLOTS];
  logic              frame_valid_d, frame_valid_q;
  logic              sync_err_d, sync_err_q;
  logic              cnt_clear, cnt_load_one, cnt_advance;
  logic [SLOT_W-1:0] slot_cnt;

  tdm_slot_counter u_slot_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .load_one (cnt_load_one),
    .advance  (cnt_advance),
    .count    (slot_cnt)
  );

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_clear     = 1'b0;
    cnt_load_one  = 1'b0;
    cnt_advance   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sync) begin
            stage_d[0]   = in_data;
            cnt_load_one = 1'b1;
            state_d      = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sync) begin
            // A sync mid-frame restarts the frame; stale staged slots are
            // simply overwritten before they can be published.
            sync_err_d   = (slot_cnt != '0);
            stage_d[0]   = in_data;
            cnt_load_one = 1'b1;
          end else if (slot_cnt == '0) begin
            sync_err_d = 1'b1;
            cnt_clear  = 1'b1;
            state_d    = HUNT;
          end else if (slot_cnt == SLOT_LAST) begin
            out_d[0]      = stage_q[0];
            out_d[1]      = stage_q[1];
            out_d[2]      = stage_q[2];
            out_d[3]      = in_data;
            frame_valid_d = 1'b1;
            cnt_advance   = 1'b1;
          end else begin
            for (int i = 1; i < NUM_SLOTS - 1; i++) begin
              if (slot_cnt == SLOT_W'(i)) stage_d[i] = in_data;
            end
            cnt_advance = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) stage_q[i] <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) out_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      stage_q       <= stage_d;
      out_q         <= out_d;
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 with WIDTH=4 and hand-computed expectations.
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_sync;
  logic [W-1:0] in_data;
  logic [W-1:0] out0, out1, out2, out3;
  logic         frame_valid;
  logic         sync_err;
  logic         locked;
  logic [1:0]   slot;

  int n_pass  = 0;
  int n_total = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .in_data     (in_data),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .slot        (slot)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  // Drive one cycle of input, then sample 1 ns after the active edge.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({out0, out1, out2, out3} !== 16'h0000)
      $display("FAIL reset_outs: got %h want 0000", {out0, out1, out2, out3});
    else n_pass++;
    n_total++;
    if ({frame_valid, sync_err, locked, slot} !== 5'b0)
      $display("FAIL reset_flags: got fv=%b se=%b lk=%b slot=%0d want all 0",
               frame_valid, sync_err, locked, slot);
    else n_pass++;
  endtask

  task automatic test_aligned();
    logic se_seen = 1'b0;
    drive(1, 1, 4'd3);
    se_seen |= sync_err;
    n_total++;
    if ({locked, slot} !== {1'b1, 2'd1})
      $display("FAIL aligned_lock: got lk=%b slot=%0d want lk=1 slot=1", locked, slot);
    else n_pass++;
    drive(1, 0, 4'd5);  se_seen |= sync_err;
    drive(1, 0, 4'd9);  se_seen |= sync_err;
    n_total++;
    if ({out0, out1, out2, out3, frame_valid} !== {16'h0000, 1'b0})
      $display("FAIL aligned_early_out: got %h fv=%b want 0000 fv=0",
               {out0, out1, out2, out3}, frame_valid);
    else n_pass++;
    drive(1, 0, 4'd12); se_seen |= sync_err;
    n_total++;
    if ({out0, out1, out2, out3} !== 16'h359C)
      $display("FAIL aligned_outs: got %h want 359c", {out0, out1, out2, out3});
    else n_pass++;
    n_total++;
    if ({frame_valid, locked, slot} !== {1'b1, 1'b1, 2'd0})
      $display("FAIL aligned_flags: got fv=%b lk=%b slot=%0d want fv=1 lk=1 slot=0",
               frame_valid, locked, slot);
    else n_pass++;
    drive(0, 0, 4'd0);  se_seen |= sync_err;
    n_total++;
    if ({frame_valid, out0, out1, out2, out3} !== {1'b0, 16'h359C})
      $display("FAIL aligned_hold: got fv=%b outs=%h want fv=0 outs=359c",
               frame_valid, {out0, out1, out2, out3});
    else n_pass++;
    n_total++;
    if (se_seen !== 1'b0)
      $display("FAIL aligned_no_sync_err: got %b want 0", se_seen);
    else n_pass++;
  endtask

  task automatic test_gapped();
    logic [W-1:0] dat [4];
    logic [1:0]   exp_slot;
    int           fv_cnt = 0;
    dat[0] = 4'd3; dat[1] = 4'd5; dat[2] = 4'd9; dat[3] = 4'd12;
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      drive(1, (b == 0), dat[b]);
      fv_cnt += int'(frame_valid);
      exp_slot = 2'(b + 1);
      n_total++;
      if (slot !== exp_slot)
        $display("FAIL gapped_slot_beat%0d: got %0d want %0d", b, slot, exp_slot);
      else n_pass++;
      if (b < 3) begin
        for (int g = 0; g < 2; g++) begin
          drive(0, 1, 4'hF);
          fv_cnt += int'(frame_valid);
          n_total++;
          if ({slot, sync_err} !== {exp_slot, 1'b0})
            $display("FAIL gapped_idle_beat%0d: got slot=%0d se=%b want slot=%0d se=0",
                     b, slot, sync_err, exp_slot);
          else n_pass++;
        end
      end
    end
    n_total++;
    if ({out0, out1, out2, out3, locked} !== {16'h359C, 1'b1})
      $display("FAIL gapped_outs: got %h lk=%b want 359c lk=1", {out0, out1, out2, out3}, locked);
    else n_pass++;
    drive(0, 0, 4'd0);
    fv_cnt += int'(frame_valid);
    n_total++;
    if (fv_cnt !== 1)
      $display("FAIL gapped_fv_count: got %0d want 1", fv_cnt);
    else n_pass++;
  endtask

  task automatic test_early_sync();
    drive(1, 1, 4'd1);
    drive(1, 0, 4'd2);
    drive(1, 1, 4'd7);
    n_total++;
    if ({sync_err, frame_valid, locked, slot} !== {1'b1, 1'b0, 1'b1, 2'd1})
      $display("FAIL early_sync_err: got se=%b fv=%b lk=%b slot=%0d want se=1 fv=0 lk=1 slot=1",
               sync_err, frame_valid, locked, slot);
    else n_pass++;
    n_total++;
    if ({out0, out1, out2, out3} !== 16'h359C)
      $display("FAIL early_sync_hold: got %h want 359c", {out0, out1, out2, out3});
    else n_pass++;
    drive(1, 0, 4'd8);
    n_total++;
    if (sync_err !== 1'b0)
      $display("FAIL early_sync_pulse: got se=%b want 0", sync_err);
    else n_pass++;
    drive(1, 0, 4'd9);
    drive(1, 0, 4'd10);
    n_total++;
    if ({out0, out1, out2, out3, frame_valid, sync_err} !== {16'h789A, 1'b1, 1'b0})
      $display("FAIL early_sync_frame: got %h fv=%b se=%b want 789a fv=1 se=0",
               {out0, out1, out2, out3}, frame_valid, sync_err);
    else n_pass++;
  endtask

  task automatic test_missing_sync();
    drive(1, 0, 4'd5);
    n_total++;
    if ({sync_err, frame_valid, locked, slot} !== {1'b1, 1'b0, 1'b0, 2'd0})
      $display("FAIL missing_sync_err: got se=%b fv=%b lk=%b slot=%0d want se=1 fv=0 lk=0 slot=0",
               sync_err, frame_valid, locked, slot);
    else n_pass++;
    n_total++;
    if ({out0, out1, out2, out3} !== 16'h789A)
      $display("FAIL missing_sync_hold: got %h want 789a", {out0, out1, out2, out3});
    else n_pass++;
    drive(1, 0, 4'd1);
    drive(1, 0, 4'd2);
    n_total++;
    if ({sync_err, locked, slot} !== {1'b0, 1'b0, 2'd0})
      $display("FAIL missing_sync_ignore: got se=%b lk=%b slot=%0d want se=0 lk=0 slot=0",
               sync_err, locked, slot);
    else n_pass++;
    drive(1, 1, 4'd2);
    drive(1, 0, 4'd4);
    drive(1, 0, 4'd6);
    drive(1, 0, 4'd8);
    n_total++;
    if ({out0, out1, out2, out3, frame_valid, locked} !== {16'h2468, 1'b1, 1'b1})
      $display("FAIL missing_sync_relock: got %h fv=%b lk=%b want 2468 fv=1 lk=1",
               {out0, out1, out2, out3}, frame_valid, locked);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1, 1, 4'hF);
    drive(1, 0, 4'hE);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({out0, out1, out2, out3, frame_valid, sync_err, locked, slot} !== 21'b0)
      $display("FAIL async_reset_now: got outs=%h fv=%b se=%b lk=%b slot=%0d want all 0",
               {out0, out1, out2, out3}, frame_valid, sync_err, locked, slot);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 4'hD);
    n_total++;
    if ({out0, out1, out2, out3, locked} !== {16'h0000, 1'b0})
      $display("FAIL async_reset_hunt: got %h lk=%b want 0000 lk=0",
               {out0, out1, out2, out3}, locked);
    else n_pass++;
    drive(1, 1, 4'd1);
    drive(1, 0, 4'd3);
    drive(1, 0, 4'd5);
    drive(1, 0, 4'd7);
    n_total++;
    if ({out0, out1, out2, out3, frame_valid} !== {16'h1357, 1'b1})
      $display("FAIL async_reset_frame: got %h fv=%b want 1357 fv=1",
               {out0, out1, out2, out3}, frame_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_frame [3];
    logic [W-1:0] d;
    exp_frame[0] = 16'h1234;
    exp_frame[1] = 16'h5678;
    exp_frame[2] = 16'h9ABC;
    for (int k = 1; k <= 12; k++) begin
      d = W'(k);
      drive(1, ((k - 1) % 4 == 0), d);
      n_total++;
      if (frame_valid !== (k % 4 == 0))
        $display("FAIL b2b_fv_beat%0d: got %b want %b", k, frame_valid, (k % 4 == 0));
      else n_pass++;
      if (k % 4 == 0) begin
        n_total++;
        if ({out0, out1, out2, out3} !== exp_frame[k/4 - 1])
          $display("FAIL b2b_outs_frame%0d: got %h want %h",
                   k / 4, {out0, out1, out2, out3}, exp_frame[k/4 - 1]);
        else n_pass++;
      end
    end
    drive(0, 0, 4'd0);
    n_total++;
    if ({frame_valid, sync_err, locked, slot} !== {1'b0, 1'b0, 1'b1, 2'd0})
      $display("FAIL b2b_end: got fv=%b se=%b lk=%b slot=%0d want fv=0 se=0 lk=1 slot=0",
               frame_valid, sync_err, locked, slot);
    else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    test_reset();
    test_aligned();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
